irq_gen: RTL and testbench
==========================

// Module: irq_gen
// PURPOSE
//  Interrupt initiator for the Yduck core's int_vld/int_rdy input. Edge-detects up to NSRC
//  external lines (typ. gpio_in), latches pending bits, and issues one-cycle int_vld pulses
//  only when the core reports int_rdy. Lowest enabled pending index wins; irq_id reports it.
// PARAMETERS
//  NSRC    16  number of interrupt source lines (1..16)
//  ACK_TO  8   cycles to wait for int_rdy to fall after a pulse before re-pending (>=2)
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     asynchronous active-low reset
//  src_in     in   NSRC  raw interrupt source lines
//  int_rdy    in   1     core ready: 1 = can accept, 0 = servicing/masked
//  int_vld    out  1     1-cycle interrupt pulse to core
//  irq_id     out  4     index of source of most recent pulse, held until next pulse
//  cfg_we     in   1     config write strobe
//  cfg_addr   in   2     0=ENABLE 1=PENDING(W1C) 2=POLARITY(0 rise,1 fall) 3=reserved
//  cfg_wdata  in   16    write data, bits >= NSRC ignored
//  cfg_rdata  out  16    registered read of cfg_addr, 1-cycle latency, upper bits 0
// BEHAVIOUR
//  Reset: int_vld=0, irq_id=0, cfg_rdata=0, ENABLE=0, PENDING=0, POLARITY=0, state=IDLE,
//   src sample reg=0, primed=0. Reset is async assert, takes effect immediately mid-pulse.
//  Edge detect: src_q <= src_in each cycle; edge[i] = primed & (POL[i] ? ~src_in&src_q : src_in&~src_q).
//   primed sets on first clock after reset release; no edge fires on that cycle (level at
//   reset exit is never an event).
//  PENDING[i] sets on edge[i] regardless of ENABLE[i]; cleared by W1C write or by issue.
//   Same-cycle set and clear (W1C or issue) of one bit: set wins, bit stays 1.
//  Writing ENABLE/POLARITY takes effect next cycle; POLARITY change never itself creates an edge.
//  FSM (2-bit):
//   IDLE : if int_rdy & |(PENDING&ENABLE): sel=lowest set index; clear PENDING[sel];
//          irq_id<=sel; -> FIRE. Else stay.
//   FIRE : int_vld=1 this cycle only; start timer=0; -> WAIT.
//   WAIT : if !int_rdy -> BUSY. Else timer++; at timer==ACK_TO-1 re-set PENDING[irq_id]
//          (pulse deemed lost) -> IDLE.
//   BUSY : wait for int_rdy=1 -> IDLE.
//  int_vld is registered (high exactly while state==FIRE); never two pulses without an
//   intervening int_rdy low, except after an ACK_TO timeout.
//  Latency: src_in first sampled at its new level on edge k -> PENDING set after k ->
//   IDLE selects at k+1 -> int_vld high for the cycle after k+1 (int_rdy=1, sole source).
//  Disabled pending source: held, not issued; issued when enabled later.
//  irq_id width fixed at 4; values >= NSRC never produced.
// CONFIGURATION
//  IRQ_GEN_SYNC_EN defined: src_in passes through a 2-flop synchronizer (reset 0) before
//   src_q/edge logic; latency grows by 2 cycles; primed sets 3 cycles after reset release.
//  Undefined: src_in assumed synchronous to clk; no synchronizer, latency as above.
// TESTING
//  1 Reset with src_in=16'hFA1C held, ENABLE=FFFF, int_rdy=1 -> no int_vld, PENDING=0.
//  2 ENABLE=0001, src_in[0] 0->1, int_rdy=1 -> int_vld 1 cycle 2 edges later, irq_id=0,
//    PENDING[0]=0 after; int_rdy low 3 cycles then high -> no second pulse.
//  3 src_in[3] and [5] rise together, ENABLE=0028 -> pulse irq_id=3; after int_rdy low/high
//    cycle, second pulse irq_id=5.
//  4 ENABLE=0004, int_rdy stuck 1 after pulse -> PENDING[2] re-set after ACK_TO=8 cycles,
//    new pulse follows, irq_id=2.
//  5 POLARITY=0002, src_in[1] 1->0 -> pulse irq_id=1; W1C 0002 on same cycle as new edge
//    -> PENDING[1] reads 1.
//  6 With IRQ_GEN_SYNC_EN: repeat 2 -> int_vld 2 cycles later than without.

Source files
------------

// File: rtl/irq_gen_if.sv
// irq_gen_if: core interrupt handshake plus config bus for irq_gen
interface irq_gen_if;
  logic        int_vld;
  logic        int_rdy;
  logic [3:0]  irq_id;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  modport master (output int_vld, irq_id, cfg_rdata, input int_rdy, cfg_we, cfg_addr, cfg_wdata);
  modport slave  (input int_vld, irq_id, cfg_rdata, output int_rdy, cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/irq_gen.sv
// irq_gen: edge-detecting interrupt initiator issuing int_vld pulses on int_rdy.
// Optional IRQ_GEN_SYNC_EN adds a 2-flop input synchronizer ahead of edge detection.
module irq_gen #(
  parameter int NSRC   = 16,
  parameter int ACK_TO = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src_in,
  irq_gen_if.master       bus
);
  localparam int TW = $clog2(ACK_TO);
  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT, S_BUSY} state_t;
  state_t state_q, state_d;
  logic [NSRC-1:0] src_s, src_q, en_q, en_d, pol_q, pol_d, pend_q, pend_d, edge_v, req, wmask;
  logic [1:0] prime_q, prime_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] irq_id_q, irq_id_d, sel;
  logic [15:0] rdata_q, rdata_d;
  logic primed, issue, repend;
`ifdef IRQ_GEN_SYNC_EN
  localparam int PRIME = 3;
  logic [NSRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_in;
      sync2_q <= sync1_q;
    end
  assign src_s = sync2_q;
`else
  localparam int PRIME = 1;
  assign src_s = src_in;
`endif
  always_comb begin
    primed = prime_q == 2'(PRIME);
    prime_d = primed ? prime_q : prime_q + 2'd1;
    edge_v = primed ? (pol_q & ~src_s & src_q) | (~pol_q & src_s & ~src_q) : '0;
    req = pend_q & en_q;
    sel = '0;
    // descending scan so the lowest requesting index is the one left in sel
    for (int i = NSRC - 1; i >= 0; i--) if (req[i]) sel = 4'(i);
    wmask = bus.cfg_wdata[NSRC-1:0];
    issue = state_q == S_IDLE && bus.int_rdy && |req;
    repend = state_q == S_WAIT && bus.int_rdy && timer_q == TW'(ACK_TO - 1);
    state_d = state_q;
    timer_d = timer_q;
    irq_id_d = irq_id_q;
    case (state_q)
      S_IDLE: if (issue) begin
        state_d = S_FIRE;
        irq_id_d = sel;
      end
      S_FIRE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: if (!bus.int_rdy) state_d = S_BUSY;
              else if (repend) state_d = S_IDLE;
              else timer_d = timer_q + TW'(1);
      default: if (bus.int_rdy) state_d = S_IDLE;
    endcase
    en_d = bus.cfg_we && bus.cfg_addr == 2'd0 ? wmask : en_q;
    pol_d = bus.cfg_we && bus.cfg_addr == 2'd2 ? wmask : pol_q;
    // new edges are OR-ed in after clearing so a coincident set always wins
    pend_d = (pend_q & ~((bus.cfg_we && bus.cfg_addr == 2'd1 ? wmask : '0) |
                         (issue ? NSRC'(1) << sel : '0)))
           | edge_v | (repend ? NSRC'(1) << irq_id_q : '0);
    rdata_d = bus.cfg_addr == 2'd0 ? 16'(en_q) :
              bus.cfg_addr == 2'd1 ? 16'(pend_q) :
              bus.cfg_addr == 2'd2 ? 16'(pol_q) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q <= '0;
      en_q <= '0;
      pol_q <= '0;
      pend_q <= '0;
      prime_q <= '0;
      timer_q <= '0;
      irq_id_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_s;
      en_q <= en_d;
      pol_q <= pol_d;
      pend_q <= pend_d;
      prime_q <= prime_d;
      timer_q <= timer_d;
      irq_id_q <= irq_id_d;
      rdata_q <= rdata_d;
    end
  assign bus.int_vld = state_q == S_FIRE;
  assign bus.irq_id = irq_id_q;
  assign bus.cfg_rdata = rdata_q;
endmodule

// File: tb/tb_irq_gen.sv
// tb_irq_gen: directed self-checking bench for irq_gen
module tb_irq_gen;
`ifdef IRQ_GEN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int EXP_LAT = 2 + SYNC_LAT;
  logic clk = 0, rst_n = 0;
  logic [15:0] src_in = '0;
  int checks = 0, errors = 0;
  irq_gen_if bus();
  irq_gen #(.NSRC(16), .ACK_TO(8)) dut (.clk(clk), .rst_n(rst_n), .src_in(src_in), .bus(bus));
  always #5 clk = ~clk;

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we = 0;
  endtask
  task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
    bus.cfg_addr = a;
    @(negedge clk);
    d = bus.cfg_rdata;
  endtask
  task automatic wait_pulse(input int bound, output int n, output bit found);
    found = 0; n = 0;
    while (!found && n < bound) begin
      @(negedge clk);
      n++;
      found = bus.int_vld === 1'b1;
    end
  endtask
  task automatic handshake;
    bus.int_rdy = 0;
    repeat (2) @(negedge clk);
    bus.int_rdy = 1;
  endtask

  task automatic test_reset;
    logic [15:0] d; int n; bit f;
    rst_n = 0; src_in = 16'hFA1C; bus.int_rdy = 1; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.int_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.int_vld); end
    checks++; if (bus.irq_id !== 4'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.irq_id); end
    checks++; if (bus.cfg_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.cfg_rdata); end
    rst_n = 1;
    cfg_write(2'd0, 16'hFFFF);
    wait_pulse(12, n, f);
    checks++; if (f) begin errors++; $display("FAIL reset_no_pulse: got pulse after %0d cycles want none", n); end
    cfg_read(2'd1, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h want 0000", d); end
    cfg_read(2'd0, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL enable_rb: got %h want ffff", d); end
  endtask

  task automatic test_single;
    logic [15:0] d; int n; bit f;
    src_in = 0;
    repeat (3) @(negedge clk);
    cfg_write(2'd1, 16'hFFFF);
    cfg_write(2'd0, 16'h0001);
    src_in = 16'h0001;
    wait_pulse(EXP_LAT + 4, n, f);
    checks++; if (!f || n != EXP_LAT) begin errors++; $display("FAIL single_lat: got found=%0b n=%0d want n=%0d", f, n, EXP_LAT); end
    checks++; if (bus.irq_id !== 4'd0) begin errors++; $display("FAIL single_id: got %0d want 0", bus.irq_id); end
    bus.int_rdy = 0;
    repeat (3) @(negedge clk);
    bus.int_rdy = 1;
    wait_pulse(12, n, f);
    checks++; if (f) begin errors++; $display("FAIL single_no_repeat: got pulse after %0d want none", n); end
    cfg_read(2'd1, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL single_pending: got %h want 0000", d); end
  endtask

  task automatic test_priority;
    logic [15:0] d; int n; bit f;
    src_in = 0;
    repeat (3) @(negedge clk);
    cfg_write(2'd1, 16'hFFFF);
    cfg_write(2'd0, 16'h0028);
    src_in = 16'h0028;
    wait_pulse(EXP_LAT + 4, n, f);
    checks++; if (!f || bus.irq_id !== 4'd3) begin errors++; $display("FAIL prio_first: got found=%0b id=%0d want id=3", f, bus.irq_id); end
    handshake();
    wait_pulse(10, n, f);
    checks++; if (!f || bus.irq_id !== 4'd5) begin errors++; $display("FAIL prio_second: got found=%0b id=%0d want id=5", f, bus.irq_id); end
    handshake();
    repeat (2) @(negedge clk);
    cfg_read(2'd1, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL prio_pending: got %h want 0000", d); end
  endtask

  task automatic test_timeout;
    logic [15:0] d; int n; bit f;
    src_in = 0;
    repeat (3) @(negedge clk);
    cfg_write(2'd1, 16'hFFFF);
    cfg_write(2'd0, 16'h0004);
    src_in = 16'h0004;
    wait_pulse(EXP_LAT + 4, n, f);
    checks++; if (!f || bus.irq_id !== 4'd2) begin errors++; $display("FAIL to_first: got found=%0b id=%0d want id=2", f, bus.irq_id); end
    wait_pulse(20, n, f);
    checks++; if (!f || n < 9 || n > 10) begin errors++; $display("FAIL to_gap: got found=%0b gap=%0d want 9..10", f, n); end
    checks++; if (bus.irq_id !== 4'd2) begin errors++; $display("FAIL to_id: got %0d want 2", bus.irq_id); end
    handshake();
    repeat (2) @(negedge clk);
    cfg_read(2'd1, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL to_pending: got %h want 0000", d); end
  endtask

  task automatic test_polarity_w1c;
    logic [15:0] d; int n; bit f;
    src_in = 0;
    repeat (3) @(negedge clk);
    cfg_write(2'd1, 16'hFFFF);
    cfg_write(2'd2, 16'h0002);
    cfg_write(2'd0, 16'h0002);
    src_in = 16'h0002;
    wait_pulse(6, n, f);
    checks++; if (f) begin errors++; $display("FAIL pol_rise_ignored: got pulse after %0d want none", n); end
    src_in = 16'h0000;
    wait_pulse(EXP_LAT + 4, n, f);
    checks++; if (!f || n != EXP_LAT || bus.irq_id !== 4'd1) begin errors++; $display("FAIL pol_fall: got found=%0b n=%0d id=%0d want n=%0d id=1", f, n, bus.irq_id, EXP_LAT); end
    handshake();
    cfg_write(2'd0, 16'h0000);
    src_in = 16'h0002;
    repeat (4) @(negedge clk);
    src_in = 16'h0000;
    repeat (SYNC_LAT) @(negedge clk);
    cfg_write(2'd1, 16'h0002);
    cfg_read(2'd1, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL w1c_set_wins: got %h want 0002", d); end
    cfg_write(2'd1, 16'h0002);
    cfg_read(2'd1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL w1c_clear: got %h want 0000", d); end
    cfg_read(2'd2, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL pol_rb: got %h want 0002", d); end
  endtask

  task automatic test_async_reset;
    int n; bit f;
    cfg_write(2'd2, 16'h0000);
    cfg_write(2'd0, 16'h0001);
    src_in = 16'h0001;
    wait_pulse(EXP_LAT + 4, n, f);
    checks++; if (!f) begin errors++; $display("FAIL ar_pulse: got none want pulse"); end
    #2 rst_n = 0;
    #1;
    checks++; if (bus.int_vld !== 1'b0) begin errors++; $display("FAIL ar_vld: got %b want 0", bus.int_vld); end
    @(negedge clk);
    rst_n = 1;
    wait_pulse(12, n, f);
    checks++; if (f) begin errors++; $display("FAIL ar_cleared: got pulse after %0d want none", n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_timeout();
    test_polarity_w1c();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
